// File: rtl/mem_pkg.sv
// Shared widths and state encoding for the load/store front end of the 16 x 8 data memory.
// States are one-hot so memory strobes decode from a single flop bit.
package mem_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  localparam int REQ_W_DEF = 1 + ADDR_W_DEF + DATA_W_DEF;
  localparam int RSP_W_DEF = 1 + DATA_W_DEF;

  localparam int S_IDLE_BIT    = 0;
  localparam int S_READ_BIT    = 1;
  localparam int S_WSTROBE_BIT = 2;
  localparam int S_WHOLD_BIT   = 3;
  localparam int S_RESP_BIT    = 4;

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    READ    = 5'b00010,
    WSTROBE = 5'b00100,
    WHOLD   = 5'b01000,
    RESP    = 5'b10000
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit.sv
// Sequential load/store front end: one request in flight, registered memory strobes.
// Load responds 2 cycles after accept, store 3; a stalled response freezes the unit.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_we,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_select,
  output logic [ADDR_W-1:0] mem_read_addr,
  input  logic [DATA_W-1:0] mem_data_out
);

  lsu_state_e        state_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              we_q;

  // Write address/data only move on a store accept, so they are stable across the strobe and hold cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
      rdata_q   <= '0;
      we_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q <= req_we;
            if (req_we) begin
              wr_addr_q <= req_addr;
              wr_data_q <= req_wdata;
              state_q   <= WSTROBE;
            end else begin
              rd_addr_q <= req_addr;
              state_q   <= READ;
            end
          end
        end
        READ: begin
          rdata_q <= mem_data_out;
          state_q <= RESP;
        end
        WSTROBE: begin
          rdata_q <= wr_data_q;
          state_q <= WHOLD;
        end
        WHOLD: begin
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready      = state_q[S_IDLE_BIT];
  assign mem_select     = state_q[S_WSTROBE_BIT];
  assign rsp_valid      = state_q[S_RESP_BIT];
  assign rsp_rdata      = rdata_q;
  assign rsp_we         = we_q;
  assign mem_write_addr = wr_addr_q;
  assign mem_data_in    = wr_data_q;
  assign mem_read_addr  = rd_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with a level-strobed 16 x 8 memory model and an in-order response scoreboard.
module tb_load_store_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_rdata;
  logic       rsp_we;
  logic [3:0] mem_write_addr;
  logic [7:0] mem_data_in;
  logic       mem_select;
  logic [3:0] mem_read_addr;
  logic [7:0] mem_data_out;

  load_store_unit #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_we         (rsp_we),
    .mem_write_addr (mem_write_addr),
    .mem_data_in    (mem_data_in),
    .mem_select     (mem_select),
    .mem_read_addr  (mem_read_addr),
    .mem_data_out   (mem_data_out)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16];
  logic [7:0] ref_mem [16];
  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
  end
  always @(posedge clk) if (mem_select) mem[mem_write_addr] <= mem_data_in;
  assign mem_data_out = mem[mem_read_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
    int         exp_cyc;
  } exp_t;
  exp_t q[$];

  bit  mon_en = 1'b0;
  bit  sel_prev = 1'b0, sel_prev2 = 1'b0, vld_prev = 1'b0;
  logic [3:0] wa_prev = '0;
  logic [7:0] din_prev = '0;
  int  sel_len = 0;
  int  sel_pulses = 0;
  int  stores_issued = 0;

  // Response scoreboard plus strobe/stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      sel_prev = 1'b0; sel_prev2 = 1'b0; vld_prev = 1'b0; sel_len = 0;
    end else begin
      if (sel_prev || sel_prev2) begin
        check("wr_addr_stable", {28'd0, mem_write_addr}, {28'd0, wa_prev});
        check("wr_data_stable", {24'd0, mem_data_in}, {24'd0, din_prev});
      end
      if (mem_select) begin
        sel_len++;
        if (!sel_prev) begin
          sel_pulses++;
          if (q.size() == 0) check("sel_without_store", 1, 0);
          else begin
            check("sel_cycle", cyc, q[0].exp_cyc - 2);
            check("sel_is_store", {31'd0, q[0].we}, 1);
            check("sel_addr", {28'd0, mem_write_addr}, {28'd0, q[0].addr});
            check("sel_data", {24'd0, mem_data_in}, {24'd0, q[0].data});
          end
        end
      end else if (sel_prev) begin
        check("sel_width", sel_len, 1);
        sel_len = 0;
      end
      if (rsp_valid && !vld_prev && q.size() != 0)
        check("rsp_latency", cyc, q[0].exp_cyc);
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) check("spurious_rsp", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.data});
          check("rsp_we", {31'd0, rsp_we}, {31'd0, e.we});
        end
      end
      sel_prev2 = sel_prev;
      sel_prev  = mem_select;
      vld_prev  = rsp_valid;
      wa_prev   = mem_write_addr;
      din_prev  = mem_data_in;
    end
  end

  task automatic do_req(input logic we, input logic [3:0] addr, input logic [7:0] data);
    int   n;
    exp_t e;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 50);
    if (!req_ready) begin
      check("req_accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    e.we = we;
    e.addr = addr;
    e.data = we ? data : ref_mem[addr];
    e.exp_cyc = cyc + (we ? 2 : 1);
    if (we) begin
      ref_mem[addr] = data;
      stores_issued++;
    end
    q.push_back(e);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("drain", q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("rst_mem_select", {31'd0, mem_select}, 0);
    check("rst_outputs", {mem_write_addr, mem_data_in, mem_read_addr, rsp_rdata, rsp_we}, 0);
    rst_n = 1'b1;

    // Reset lands while the write strobe is high.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'h9; req_wdata = 8'h99;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_sel", {31'd0, mem_select}, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_sel", {31'd0, mem_select}, 0);
    check("midrst_outputs", {mem_write_addr, mem_data_in, mem_read_addr, rsp_rdata, rsp_we, rsp_valid}, 0);
    check("midrst_req_ready", {31'd0, req_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", {31'd0, req_ready}, 1);
    mon_en = 1'b1;

    do_req(1'b1, 4'h7, 8'h55);
    wait_drain();
    do_req(1'b0, 4'h7, 8'h00);
    wait_drain();
    do_req(1'b1, 4'h0, 8'hA0);
    do_req(1'b1, 4'hF, 8'hB0);
    wait_drain();
    check("rd_addr_holds", {28'd0, mem_read_addr}, 32'h7);
    do_req(1'b0, 4'h0, 8'h00);
    do_req(1'b0, 4'hF, 8'h00);
    wait_drain();

    // Stalled response: everything frozen, intruding request ignored.
    rsp_ready = 1'b0;
    do_req(1'b0, 4'hF, 8'h00);
    begin
      int n;
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req_valid = (i == 0); req_we = 1'b1; req_addr = 4'h3; req_wdata = 8'hEE;
      @(negedge clk);
      check("hold_rsp_valid", {31'd0, rsp_valid}, 1);
      check("hold_rsp_rdata", {24'd0, rsp_rdata}, 32'hB0);
      check("hold_req_ready", {31'd0, req_ready}, 0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_drain();
    do_req(1'b0, 4'h3, 8'h00);
    wait_drain();

    for (int i = 0; i < 12; i++) begin
      logic [3:0] a;
      a = 4'($urandom_range(4, 14));
      do_req(1'($urandom_range(0, 1)), a, 8'($urandom));
    end
    wait_drain();
    repeat (4) @(negedge clk);
    check("sel_pulses_vs_stores", sel_pulses, stores_issued);
    check("idle_rsp_valid", {31'd0, rsp_valid}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
